alu_seq: RTL and testbench

//  Registered, handshaked successor to the combinational datapath ALU.

---
 rtl/alu_seq_if.sv | 21 ++
 rtl/alu_seq.sv | 73 +++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result valid-ready bus between operand fetch, alu_seq and writeback.
interface alu_seq_if #(parameter int REG_WIDTH = 32);
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] in1;
  logic [REG_WIDTH-1:0] in2;
  logic [3:0]           alu_control;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] result;
  logic                 zero;
  logic                 sign;
  modport master (
    output in_valid, in1, in2, alu_control, out_ready,
    input  in_ready, out_valid, result, zero, sign
  );
  modport slave (
    input  in_valid, in1, in2, alu_control, out_ready,
    output in_ready, out_valid, result, zero, sign
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered handshaked ALU with shifts, flags and an iterative shift-add multiplier.
module alu_seq #(
  parameter int REG_WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset_b,
  alu_seq_if.slave bus
);
  localparam int SH_W = $clog2(REG_WIDTH);
  localparam logic [0:0] IDLE = 1'b0, MUL = 1'b1;
  localparam logic [3:0] OP_MUL = 4'b1000;
  logic [0:0]           state;
  logic [REG_WIDTH-1:0] mcand, mplier, acc, acc_nxt, alu_res, r_nxt;
  logic [SH_W-1:0]      cnt, sh;
  logic                 slot_free, accept, last, load;
  assign sh           = bus.in2[SH_W-1:0];
  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == IDLE) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last         = (state == MUL) && (cnt == SH_W'(REG_WIDTH - 1));
  assign acc_nxt      = acc + (mplier[0] ? mcand : '0);
  // the last multiply step is folded into the result load
  assign load         = (accept && bus.alu_control != OP_MUL) || (last && slot_free);
  assign r_nxt        = (state == MUL) ? acc_nxt : alu_res;
  always_comb begin
    alu_res = bus.in1 + bus.in2;
    case (bus.alu_control)
      4'b0000: alu_res = bus.in1 & bus.in2;
      4'b0001: alu_res = bus.in1 | bus.in2;
      4'b0011: alu_res = bus.in1 ^ bus.in2;
      4'b0110: alu_res = bus.in1 - bus.in2;
      4'b0100: alu_res = bus.in1 << sh;
      4'b0101: alu_res = bus.in1 >> sh;
      4'b0111: alu_res = REG_WIDTH'($signed(bus.in1) >>> sh);
      default: alu_res = bus.in1 + bus.in2;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.sign      <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
    end else begin
      if (load) begin
        bus.result    <= r_nxt;
        bus.zero      <= ~|r_nxt;
        bus.sign      <= r_nxt[REG_WIDTH-1];
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (accept && bus.alu_control == OP_MUL) begin
        mcand  <= bus.in1;
        mplier <= bus.in2;
        acc    <= '0;
        cnt    <= '0;
        state  <= MUL;
      end else if (state == MUL && !(last && !slot_free)) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand-written corner sequences and randomized scoreboard run for alu_seq.
module tb_alu_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;
  alu_seq_if #(.REG_WIDTH(W)) bus ();
  alu_seq #(.REG_WIDTH(W)) dut (.clk(clk), .reset_b(reset_b), .bus(bus.slave));
  int tests = 0, fails = 0, cyc = 0;
  logic [W-1:0] expq[$];
  logic [W-1:0] e;
  logic rand_bp = 1'b0;
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, s;
  } vec_t;
  vec_t v[15];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned s = b % W;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0100: return a << s;
      4'b0101: return a >> s;
      4'b0111: return $signed(a) >>> s;
      4'b1000: return a * b;
      default: return a + b;
    endcase
  endfunction
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // scoreboard: every consumed result must match the model, in order
  always @(negedge clk) begin
    if (reset_b && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected output: got %h expected none", bus.result);
      end else begin
        e = expq.pop_front();
        check("sb result", bus.result, e);
        check("sb zero", W'(bus.zero), W'(e == '0));
        check("sb sign", W'(bus.sign), W'(e[W-1]));
      end
    end
  end
  always @(posedge clk) if (rand_bp) #1 bus.out_ready = ($urandom % 4) != 0;
  // call between posedge+1 and the next negedge; returns at posedge+1 after the accept edge
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.alu_control = op;
    bus.in1 = a;
    bus.in2 = b;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send timeout: op %b in_ready %b expected 1", op, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    expq.push_back(ref_alu(op, a, b));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL out_valid timeout: got 0 expected 1");
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, seen, n;
    logic [3:0] ops[11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h4, 4'h5, 4'h7, 4'h8, 4'hF, 4'h9};
    v[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
    v[1]  = '{4'b0110, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1'b1};
    v[2]  = '{4'b0000, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0};
    v[3]  = '{4'b0001, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1'b0};
    v[4]  = '{4'b0011, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1'b0};
    v[5]  = '{4'b0100, 32'h1,        32'd31,       32'h80000000, 1'b0, 1'b1};
    v[6]  = '{4'b0101, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0};
    v[7]  = '{4'b0111, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1};
    v[8]  = '{4'b0100, 32'h1234,     32'h20,       32'h1234,     1'b0, 1'b0};
    v[9]  = '{4'b0111, 32'h87654321, 32'h0,        32'h87654321, 1'b0, 1'b1};
    v[10] = '{4'b1111, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    v[11] = '{4'b1001, 32'd1,        32'd1,        32'd2,        1'b0, 1'b0};
    v[12] = '{4'b1000, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0};
    v[13] = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0};
    v[14] = '{4'b1000, 32'h0,        32'h12345678, 32'h0,        1'b1, 1'b0};
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.alu_control = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", W'(bus.out_valid), 0);
    check("reset result", bus.result, 0);
    check("reset flags", W'({bus.zero, bus.sign}), 0);
    reset_b = 1'b1;
    @(posedge clk);
    #1 check("idle in_ready", W'(bus.in_ready), 1);
    for (int i = 0; i < 15; i++) begin
      send(v[i].op, v[i].a, v[i].b);
      t0 = cyc;
      wait_valid();
      check($sformatf("vec%0d result", i), bus.result, v[i].r);
      check($sformatf("vec%0d zero", i), W'(bus.zero), W'(v[i].z));
      check($sformatf("vec%0d sign", i), W'(bus.sign), W'(v[i].s));
      check($sformatf("vec%0d latency", i), W'(cyc - t0), (v[i].op == 4'b1000) ? 32 : 0);
      @(posedge clk);
      #1;
    end
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(4'b0010, W'(i * 3), W'(32'h100 + i));
      check($sformatf("stream%0d valid", i), W'(bus.out_valid), 1);
      check($sformatf("stream%0d result", i), bus.result, W'(i * 4 + 32'h100));
    end
    check("stream cycles", W'(cyc - t0), 8);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd2);
    bus.in_valid = 1'b1;
    bus.in1 = 32'd9;
    bus.in2 = 32'd9;
    repeat (3) begin
      @(negedge clk);
      check("bp in_ready", W'(bus.in_ready), 0);
      check("bp result held", bus.result, 3);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp drained", W'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    send(4'b1000, 32'd6, 32'd7);
    repeat (40) @(negedge clk);
    check("mul stall valid", W'(bus.out_valid), 1);
    check("mul stall in_ready", W'(bus.in_ready), 0);
    check("mul stall result", bus.result, 42);
    @(negedge clk);
    check("mul stall held", bus.result, 42);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(4'b1000, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #2 reset_b = 1'b0;
    #1;
    check("mid-mul reset valid", W'(bus.out_valid), 0);
    check("mid-mul reset result", bus.result, 0);
    expq.delete();
    @(posedge clk);
    #1 reset_b = 1'b1;
    @(negedge clk);
    check("post reset in_ready", W'(bus.in_ready), 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no stale mul output", W'(seen), 0);
    @(posedge clk);
    #1 rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(ops[$urandom_range(0, 10)], W'($urandom), W'($urandom));
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    check("drain pending", W'(expq.size()), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
